mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter peripheral. It is the responder on the CPU data bus, in parallel with data memory, and it is the source of the CPU's `IRQ` input. CPU stores push bytes into a small TX FIFO, and an 8N1 serialiser drives the `tx` pin. The block raises `IRQ` when the FIFO has drained, which is the first external-device support for the pipeline.

Parameters:
- BASE_ADDR, 32'h40000000, word-aligned base of the 16-byte register window
- BAUD_DIV, 5208, clock cycles per UART bit (≥2); use 4 in simulation
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, ≤128

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- MemRead  in  1  bus read strobe (EX/MEM stage)
- MemWrite  in  1  bus write strobe (EX/MEM stage)
- address  in  32  byte address
- write_data  in  32  store data
- read_data  out  32  load data, combinational
- hit  out  1  address[31:4] == BASE_ADDR[31:4]; used by the top level to mux `read_data` against data memory
- tx  out  1  serial line, idle high
- IRQ  out  1  interrupt request to CPU, registered

Behaviour:
- Clock and reset:
  - Single clock `clk`. `reset` is synchronous and active-high.
  - Reset values: `tx`=1, `IRQ`=0, FIFO empty, FSM IDLE, baud/bit counters 0, CTRL=0, overflow=0.
  - Reset mid-frame aborts the frame: `tx`=1 at the next edge and FIFO contents are discarded.
- Register map (offset = address[3:2]; address[1:0] ignored):
  - 0x0 TXDATA. Write pushes write_data[7:0]. Reads as 0.
  - 0x4 STATUS, read-only:
    - bit0 busy (FSM≠IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - [15:8] FIFO count
    - all other bits 0
  - 0x8 CTRL:
    - bit0 irq_en (R/W)
    - bit1 irq_pending (read; write 1 clears)
    - bit2 write 1 clears overflow (reads 0)
  - 0xC reserved: reads 0, writes ignored.
- Bus rules:
  - Writes take effect on the clock edge when MemWrite & hit.
  - `read_data` = selected register when MemRead & hit, else 0. It is combinational, so loads need no extra latency, matching data memory.
  - Reads have no side effects.
- FIFO:
  - Push = TXDATA write. A push when full (evaluated before the edge) is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle while not full: both happen and count is unchanged.
- Serialiser FSM (IDLE, START, DATA, STOP), LSB first:
  - IDLE → START when FIFO non-empty. The byte is popped into a shift register and `tx`=0 is registered on that same edge, so `tx` falls one edge after the push edge.
  - START, each DATA bit (8) and STOP each last exactly BAUD_DIV cycles. A frame is 10*BAUD_DIV cycles.
  - At the end of STOP: if the FIFO is non-empty, go directly to START with no idle gap (back-to-back frames). Otherwise go to IDLE.
- Interrupt:
  - irq_pending sets on the edge that ends STOP with the FIFO empty.
  - A CTRL write with bit1=1 clears irq_pending. If set and clear coincide, set wins.
  - `IRQ` = irq_pending & irq_en, registered.
  - irq_pending sets regardless of irq_en.
- Arithmetic:
  - Baud counter width $clog2(BAUD_DIV). It wraps to 0 at BAUD_DIV-1.
  - Bit index is 3 bits.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.

Decomposition:
- Package `mmio_pkg`:
  - register offsets (TXDATA/STATUS/CTRL)
  - STATUS and CTRL bit indices
  - uart_state_t enum (IDLE, START, DATA, STOP)
  - default BASE_ADDR constant
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - ports push, pop, din, dout, full, empty, count
  - same clk/reset convention

Test Plan:
1. Reset, then read STATUS → 0x00000004. `tx`=1, `IRQ`=0, `hit`=0 for address 0x00000010.
2. BAUD_DIV=4, store 0x55 to BASE+0x0:
   - `tx` low from the next edge for 4 cycles, then 1,0,1,0,1,0,1,0, each 4 cycles, then stop high 4 cycles (40 cycles total).
   - STATUS bit0 =1 throughout the frame, 0 afterwards.
3. FIFO_DEPTH=4, six TXDATA stores on consecutive cycles:
   - The first five are accepted (one is popped immediately) and the sixth is dropped.
   - STATUS bit3=1.
   - Five back-to-back frames = 200 cycles with no idle high between frames.
   - CTRL write 0x4 clears overflow.
4. Interrupt enabled:
   - CTRL=0x1, store 0xA3. `IRQ` rises one edge after the end-of-STOP edge and stays high.
   - CTRL write 0x3 drops `IRQ` the next edge.
   - Repeat with CTRL=0x0: irq_pending reads 1 via CTRL, `IRQ` stays 0.
5. Address decode:
   - Store to BASE+0x10 and to 0x00000000: no push, `hit`=0, `read_data`=0.
   - Load from BASE+0xC → 0.
   - Load from BASE+0x5 → STATUS (low bits ignored).
6. Reset mid-frame: assert reset during data bit 3 with 2 bytes queued → `tx`=1 after the edge, STATUS=0x00000004, no further frames.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped UART transmitter.
// Contents:
//   - the default register window base address
//   - register offsets, selected by address[3:2]
//   - bit positions of the STATUS and CTRL fields
//   - the serialiser state type
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Register offsets (word index within the 16-byte window)
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_MSB = 15;

    // CTRL bit positions
    localparam int CT_IRQ_EN   = 0;
    localparam int CT_IRQ_PEND = 1;
    localparam int CT_OVF_CLR  = 2;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a synchronous, active-high reset.
// Ports:
//   clk, reset   - clock; synchronous active-high reset that empties the FIFO
//   push, din    - write request and data; a push while full is ignored
//   pop, dout    - read request; dout always shows the head entry
//   full, empty  - occupancy flags
//   count        - number of stored entries, one bit wider than the pointers
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a drain interrupt.
// Ports:
//   clk, reset          - system clock; synchronous active-high reset
//   MemRead, MemWrite   - bus strobes from the EX/MEM stage
//   address, write_data - byte address and store data
//   read_data           - combinational load data (0 unless MemRead & hit)
//   hit                 - address falls inside the 16-byte register window
//   tx                  - serial line, idle high
//   IRQ                 - registered irq_pending & irq_en
// Register map (address[3:2]):
//   0 TXDATA - write pushes a byte
//   1 STATUS - busy, full, empty, overflow, count
//   2 CTRL   - irq_en, irq_pending (write-1-clear), overflow clear
//   3 reserved
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          BAUD_DIV   = 5208,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        tx,
    output logic        IRQ
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_pend_q, irq_pend_d;
    logic          ovf_q, ovf_d;
    logic          irq_q;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic [1:0]    sel;
    logic          wr_en, txdata_wr, ctrl_wr;
    logic          baud_tick, frame_done;
    logic [31:0]   status_word, ctrl_word;

    // Bits of the bus that carry no meaning for this block.
    logic          unused_bits;
    assign unused_bits = ^{address[1:0], write_data[31:8]};

    // ---------------- Bus decode ----------------
    assign hit       = (address[31:4] == BASE_ADDR[31:4]);
    assign sel       = address[3:2];
    assign wr_en     = MemWrite & hit;
    assign txdata_wr = wr_en & (sel == OFF_TXDATA);
    assign ctrl_wr   = wr_en & (sel == OFF_CTRL);

    // ---------------- TX FIFO ----------------
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (txdata_wr),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- Serialiser ----------------
    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            UART_IDLE: begin
                // Pop and drive the start bit on the same edge.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    state_d  = UART_START;
                end
            end
            UART_START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = UART_START;
                    end else begin
                        state_d    = UART_IDLE;
                        frame_done = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // ---------------- Control / status ----------------
    always_comb begin
        irq_en_d   = ctrl_wr ? write_data[CT_IRQ_EN] : irq_en_q;
        // Set beats a coincident write-1-clear.
        irq_pend_d = frame_done | (irq_pend_q & ~(ctrl_wr & write_data[CT_IRQ_PEND]));
        // A push into a full FIFO is dropped even if a pop happens on the same edge.
        ovf_d      = (txdata_wr & fifo_full) | (ovf_q & ~(ctrl_wr & write_data[CT_OVF_CLR]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_pend_q & irq_en_q;
        end
    end

    assign tx  = tx_q;
    assign IRQ = irq_q;

    // ---------------- Read path ----------------
    always_comb begin
        status_word                         = '0;
        status_word[ST_BUSY]                = (state_q != UART_IDLE);
        status_word[ST_FULL]                = fifo_full;
        status_word[ST_EMPTY]               = fifo_empty;
        status_word[ST_OVF]                 = ovf_q;
        status_word[ST_CNT_MSB:ST_CNT_LSB]  = 8'(fifo_count);

        ctrl_word                           = '0;
        ctrl_word[CT_IRQ_EN]                = irq_en_q;
        ctrl_word[CT_IRQ_PEND]              = irq_pend_q;
    end

    always_comb begin
        read_data = '0;
        if (MemRead && hit) begin
            case (sel)
                OFF_STATUS: read_data = status_word;
                OFF_CTRL:   read_data = ctrl_word;
                default:    read_data = '0;
            endcase
        end
    end

endmodule
